char_input_cond: RTL and testbench

Button conditioning and physics-tick stage that sits directly upstream of the character physics/FSM block. It synchronises and debounces the raw left/right/jump buttons and generates the periodic physics tick. Each button press becomes exactly one request that is held stable for a full tick period, so the slow character-clock domain cannot miss or double-count it. It also supplies a debounced, tick-aligned jump-hold level for charge timing.

---
 rtl/char_input_cond.sv | 140 ++++++++++++++
 tb/tb_char_input_cond.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_input_cond.sv
// char_input_cond: synchronises and debounces the three character buttons,
// generates the periodic physics tick and turns each debounced press into a
// single request held for one full tick period (left > right > jump).
module char_input_cond #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 1666667,
    parameter int CNT_W           = 21
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       left_btn,
    input  logic       right_btn,
    input  logic       jump_btn,
    output logic       phys_tick,
    output logic       left_req,
    output logic       right_req,
    output logic       jump_req,
    output logic       jump_hold,
    output logic [2:0] pend_dbg
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    // Bit order everywhere is {jump, right, left}.
    logic [2:0]       btn_raw;
    logic [2:0]       sync1_reg;
    logic [2:0]       sync2_reg;
    logic [2:0]       stable;
    logic [2:0]       stable_d_reg;
    logic [2:0]       rise;
    logic [2:0]       pend_reg;
    logic [2:0]       pend_next;
    logic [2:0]       req_reg;
    logic [2:0]       req_next;
    logic             jump_hold_reg;
    logic [CNT_W-1:0] tick_cnt_reg;

    assign btn_raw = {jump_btn, right_btn, left_btn};

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_reg <= 3'b000;
            sync2_reg <= 3'b000;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_deb
            logic [CNT_W-1:0] deb_cnt_reg;
            logic             stable_reg;

            // Count consecutive disagreeing cycles; any agreeing cycle restarts the count.
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    deb_cnt_reg <= '0;
                    stable_reg  <= 1'b0;
                end else if (sync2_reg[gi] == stable_reg) begin
                    deb_cnt_reg <= '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    stable_reg  <= ~stable_reg;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + CNT_W'(1);
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    // Delayed copy of the debounced levels for 0->1 edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stable_d_reg <= 3'b000;
        end else begin
            stable_d_reg <= stable;
        end
    end

    assign rise = stable & ~stable_d_reg;

    // Free-running physics tick divider.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tick_cnt_reg <= '0;
        end else if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
        end
    end

    assign phys_tick = (tick_cnt_reg == TICK_LAST);

    // On a tick, issue the highest-priority pending request; a same-cycle rise re-arms its flag.
    always_comb begin
        req_next  = req_reg;
        pend_next = pend_reg;
        if (phys_tick) begin
            req_next = 3'b000;
            if (pend_reg[0]) begin
                req_next = 3'b001;
            end else if (pend_reg[1]) begin
                req_next = 3'b010;
            end else if (pend_reg[2]) begin
                req_next = 3'b100;
            end
            pend_next = pend_reg & ~req_next;
        end
        pend_next = pend_next | rise;
    end

    // Pending flags, request outputs and tick-aligned jump level.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pend_reg      <= 3'b000;
            req_reg       <= 3'b000;
            jump_hold_reg <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            req_reg  <= req_next;
            if (phys_tick) begin
                jump_hold_reg <= stable[2];
            end
        end
    end

    assign left_req  = req_reg[0];
    assign right_req = req_reg[1];
    assign jump_req  = req_reg[2];
    assign jump_hold = jump_hold_reg;
    assign pend_dbg  = pend_reg;

endmodule

// File: tb/tb_char_input_cond.sv
// tb_char_input_cond: directed scenarios plus randomized button activity,
// checked every cycle against a behavioural model of the button pipeline.
module tb_char_input_cond;

    localparam int DEB  = 4;
    localparam int TDIV = 16;

    logic       sys_clk;
    logic       sys_rst;
    logic       left_btn;
    logic       right_btn;
    logic       jump_btn;
    logic       phys_tick;
    logic       left_req;
    logic       right_req;
    logic       jump_req;
    logic       jump_hold;
    logic [2:0] pend_dbg;

    int n_pass;
    int n_total;

    char_input_cond #(
        .DEBOUNCE_CYCLES(DEB),
        .TICK_DIV       (TDIV),
        .CNT_W          (5)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .left_btn (left_btn),
        .right_btn(right_btn),
        .jump_btn (jump_btn),
        .phys_tick(phys_tick),
        .left_req (left_req),
        .right_req(right_req),
        .jump_req (jump_req),
        .jump_hold(jump_hold),
        .pend_dbg (pend_dbg)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Behavioural model: raw -> two-sample delay -> "last DEB samples all
    // disagree" debounce -> rise -> pending set -> issue lowest index on tick.
    logic [2:0] m_s1, m_s2, m_stable, m_stable_d, m_pend, m_req;
    logic       m_hold;
    logic       m_tick;
    int         m_tcnt;
    logic [2:0] m_hist[$];

    assign m_tick = (m_tcnt == TDIV - 1);

    always @(posedge sys_clk or posedge sys_rst) begin : model
        logic [2:0] rise_v;
        logic [2:0] flip_v;
        if (sys_rst) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0; m_stable_d = 0;
            m_pend = 0; m_req = 0; m_hold = 0; m_tcnt = 0;
            m_hist = {};
            for (int i = 0; i < DEB; i++) m_hist.push_back(3'b000);
        end else begin
            rise_v = m_stable & ~m_stable_d;
            m_hist.push_back(m_s2);
            if (m_hist.size() > DEB) void'(m_hist.pop_front());
            flip_v = 3'b111;
            foreach (m_hist[i]) flip_v = flip_v & (m_hist[i] ^ m_stable);
            if (m_tick) begin
                m_req = 3'b000;
                for (int b = 0; b < 3; b++) begin
                    if (m_pend[b]) begin
                        m_req = 3'(1 << b);
                        break;
                    end
                end
                m_pend = m_pend & ~m_req;
                m_hold = m_stable[2];
            end
            m_pend     = m_pend | rise_v;
            m_stable_d = m_stable;
            m_stable   = m_stable ^ flip_v;
            m_s2       = m_s1;
            m_s1       = {jump_btn, right_btn, left_btn};
            m_tcnt     = (m_tcnt + 1) % TDIV;
        end
    end

    logic [7:0] dut_vec, mdl_vec;
    assign dut_vec = {phys_tick, jump_req, right_req, left_req, jump_hold, pend_dbg};
    assign mdl_vec = {m_tick, m_req, m_hold, m_pend};

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; left_btn = 0; right_btn = 0; jump_btn = 0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; left_btn = 0; right_btn = 0; jump_btn = 0;
        #1;
        n_total++;
        if (dut_vec !== 8'h00) $display("FAIL reset_async got=%b exp=%b", dut_vec, 8'h00);
        else n_pass++;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge sys_clk);
            n_total++;
            if (dut_vec !== mdl_vec) $display("FAIL reset_model cyc=%0d got=%b exp=%b", n, dut_vec, mdl_vec);
            else n_pass++;
            n_total++;
            if (dut_vec !== {(n % TDIV == TDIV - 1), 7'b0})
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", n, dut_vec, {(n % TDIV == TDIV - 1), 7'b0});
            else n_pass++;
        end
    endtask

    task automatic test_left_single();
        do_reset();
        for (int n = 1; n <= 60; n++) begin
            left_btn = (n >= 20);
            @(negedge sys_clk);
            n_total++;
            if (dut_vec !== mdl_vec) $display("FAIL left_model cyc=%0d got=%b exp=%b", n, dut_vec, mdl_vec);
            else n_pass++;
            n_total++;
            if ({jump_req, right_req, left_req, pend_dbg} !== {2'b00, (n >= 32 && n <= 47), 2'b00, (n >= 26 && n <= 31)})
                $display("FAIL left_timing cyc=%0d got=%b%b%b/%b", n, jump_req, right_req, left_req, pend_dbg);
            else n_pass++;
        end
        left_btn = 0;
    endtask

    task automatic test_left_right();
        logic [2:0] exp_pend;
        do_reset();
        for (int n = 1; n <= 50; n++) begin
            left_btn  = (n >= 2 && n <= 12);
            right_btn = (n >= 2 && n <= 12);
            @(negedge sys_clk);
            exp_pend = (n >= 8 && n <= 15) ? 3'b011 : (n >= 16 && n <= 31) ? 3'b010 : 3'b000;
            n_total++;
            if (dut_vec !== mdl_vec) $display("FAIL lr_model cyc=%0d got=%b exp=%b", n, dut_vec, mdl_vec);
            else n_pass++;
            n_total++;
            if ({right_req, left_req, pend_dbg} !== {(n >= 32 && n <= 47), (n >= 16 && n <= 31), exp_pend})
                $display("FAIL lr_order cyc=%0d got=%b%b/%b exp_pend=%b", n, right_req, left_req, pend_dbg, exp_pend);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int n = 1; n <= 30; n++) begin
            jump_btn = (n >= 10 && n <= 12);
            @(negedge sys_clk);
            n_total++;
            if (dut_vec !== mdl_vec) $display("FAIL glitch_model cyc=%0d got=%b exp=%b", n, dut_vec, mdl_vec);
            else n_pass++;
            n_total++;
            if ({jump_req, pend_dbg} !== 4'b0000) $display("FAIL glitch_quiet cyc=%0d got=%b/%b exp=0/000", n, jump_req, pend_dbg);
            else n_pass++;
        end
    endtask

    task automatic test_multi_press();
        int req_cycles;
        req_cycles = 0;
        do_reset();
        for (int n = 1; n <= 70; n++) begin
            jump_btn = (n >= 28 && n <= 33) || (n >= 39 && n <= 44);
            @(negedge sys_clk);
            if (jump_req) req_cycles++;
            n_total++;
            if (dut_vec !== mdl_vec) $display("FAIL multi_model cyc=%0d got=%b exp=%b", n, dut_vec, mdl_vec);
            else n_pass++;
            n_total++;
            if (jump_req !== (n >= 48 && n <= 63)) $display("FAIL multi_req cyc=%0d got=%b exp=%b", n, jump_req, (n >= 48 && n <= 63));
            else n_pass++;
        end
        n_total++;
        if (req_cycles != TDIV) $display("FAIL multi_collapse got=%0d exp=%0d", req_cycles, TDIV);
        else n_pass++;
    endtask

    task automatic test_jump_hold();
        do_reset();
        for (int n = 1; n <= 85; n++) begin
            jump_btn = (n >= 5 && n <= 60);
            @(negedge sys_clk);
            n_total++;
            if (dut_vec !== mdl_vec) $display("FAIL hold_model cyc=%0d got=%b exp=%b", n, dut_vec, mdl_vec);
            else n_pass++;
            n_total++;
            if ({jump_req, jump_hold} !== {(n >= 16 && n <= 31), (n >= 16 && n <= 79)})
                $display("FAIL hold_timing cyc=%0d got=%b%b exp=%b%b", n, jump_req, jump_hold, (n >= 16 && n <= 31), (n >= 16 && n <= 79));
            else n_pass++;
        end
        jump_btn = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int n = 1; n <= 28; n++) begin
            left_btn  = (n >= 2 && n <= 12);
            right_btn = (n >= 2 && n <= 12);
            @(negedge sys_clk);
        end
        n_total++;
        if ({left_req, pend_dbg} !== 4'b1010) $display("FAIL arst_pre got=%b/%b exp=1/010", left_req, pend_dbg);
        else n_pass++;
        #2;
        sys_rst = 1'b1;
        #1;
        n_total++;
        if (dut_vec !== 8'h00) $display("FAIL arst_immediate got=%b exp=%b", dut_vec, 8'h00);
        else n_pass++;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge sys_clk);
            n_total++;
            if (dut_vec !== mdl_vec) $display("FAIL arst_model cyc=%0d got=%b exp=%b", n, dut_vec, mdl_vec);
            else n_pass++;
            n_total++;
            if ({jump_req, right_req, left_req, pend_dbg} !== 6'b0) $display("FAIL arst_noreq cyc=%0d got=%b%b%b/%b", n, jump_req, right_req, left_req, pend_dbg);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 1; n <= 1500; n++) begin
            if ($urandom_range(9) == 0) left_btn  = ~left_btn;
            if ($urandom_range(9) == 0) right_btn = ~right_btn;
            if ($urandom_range(9) == 0) jump_btn  = ~jump_btn;
            @(negedge sys_clk);
            n_total++;
            if (dut_vec !== mdl_vec) $display("FAIL random_model cyc=%0d got=%b exp=%b", n, dut_vec, mdl_vec);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        sys_rst = 0; left_btn = 0; right_btn = 0; jump_btn = 0;
        test_reset();
        test_left_single();
        test_left_right();
        test_glitch();
        test_multi_press();
        test_jump_hold();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
